// File: rtl/operand_fetch_unit.sv
// operand_fetch_unit: register file with busy scoreboard feeding a one-entry operand register.
// Optional feature macro BYPASS_EN: same-cycle writeback forwarding into the read path and busy check.
module operand_fetch_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs,
    input  logic [ADDR_W-1:0] req_rt,
    input  logic [ADDR_W-1:0] req_rd,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [ADDR_W-1:0] op_rd,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);
    localparam int N = 2 ** ADDR_W;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] regs [N];
    logic [N-1:0]      busy, busy_eff, set_mask, clr_mask;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              accept;

    assign clr_mask = wb_en ? (N'(1) << wb_addr) : '0;
    assign set_mask = (accept && req_rd != '0) ? (N'(1) << req_rd) : '0;

`ifdef BYPASS_EN
    logic wb_live;
    assign wb_live  = wb_en && wb_addr != '0;
    assign busy_eff = busy & ~clr_mask;
    assign rs_val   = (wb_live && wb_addr == req_rs) ? wb_data : regs[req_rs];
    assign rt_val   = (wb_live && wb_addr == req_rt) ? wb_data : regs[req_rt];
`else
    assign busy_eff = busy;
    assign rs_val   = regs[req_rs];
    assign rt_val   = regs[req_rt];
`endif

    assign op_valid  = state == FULL;
    assign req_ready = (!op_valid || op_ready) && !busy_eff[req_rs] && !busy_eff[req_rt] && !busy_eff[req_rd];
    assign accept    = req_valid && req_ready;

    // Output slot fills on accept and drains when consumed without a replacement
    always_comb begin
        state_next = state;
        state_next = accept ? FULL : (op_ready ? EMPTY : state);
    end

    // Output state register
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= EMPTY;
        else state <= state_next;

    // Operand capture; held values are untouched until the next accept
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r1    <= '0;
            r2    <= '0;
            op_rd <= '0;
        end else if (accept) begin
            r1    <= rs_val;
            r2    <= rt_val;
            op_rd <= req_rd;
        end

    // Scoreboard: a new claim on a register outranks a same-cycle release
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) busy <= '0;
        else busy <= (busy & ~clr_mask) | set_mask;

    // Register file; entry 0 is never written so it always reads zero
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) for (int i = 0; i < N; i++) regs[i] <= '0;
        else if (wb_en && wb_addr != '0) regs[wb_addr] <= wb_data;
endmodule

// File: tb/tb_operand_fetch_unit.sv
// tb_operand_fetch_unit: directed and random checks of operand_fetch_unit against an array-based model.
module tb_operand_fetch_unit;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0, req_ready;
    logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0;
    logic        op_valid, op_ready = 1'b1;
    logic [31:0] r1, r2;
    logic [4:0]  op_rd;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;

    int total = 0;
    int bad = 0;

    logic [31:0] m_reg [32];
    bit          m_busy [32];
    bit          m_valid;
    logic [31:0] m_r1, m_r2;
    logic [4:0]  m_rd;
    bit          last_acc;

    operand_fetch_unit dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .op_valid(op_valid), .op_ready(op_ready),
        .r1(r1), .r2(r2), .op_rd(op_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit bypass_on();
`ifdef BYPASS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit busy_seen(input logic [4:0] i);
        return m_busy[i] && !(bypass_on() && wb_en && wb_addr == i);
    endfunction

    function automatic logic [31:0] read_val(input logic [4:0] i);
        if (i == 0) return 32'h0;
        if (bypass_on() && wb_en && wb_addr == i) return wb_data;
        return m_reg[i];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_valid = 1'b0;
        m_r1 = '0;
        m_r2 = '0;
        m_rd = '0;
    endtask

    // Async reset asserted at the current negedge, released one cycle later
    task automatic apply_reset();
        rstn = 1'b0;
        #1;
        model_clear();
        chk("rst_op_valid", {31'b0, op_valid}, 32'd0);
        chk("rst_r1", r1, 32'd0);
        chk("rst_r2", r2, 32'd0);
        chk("rst_op_rd", {27'b0, op_rd}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // One clock: inputs were driven at the preceding negedge
    task automatic cycle();
        bit exp_rdy;
        #1;
        exp_rdy = (!m_valid || op_ready) && !busy_seen(req_rs) && !busy_seen(req_rt) && !busy_seen(req_rd);
        chk("req_ready", {31'b0, req_ready}, {31'b0, exp_rdy});
        last_acc = req_valid && exp_rdy;
        if (last_acc) begin
            m_r1 = read_val(req_rs);
            m_r2 = read_val(req_rt);
            m_rd = req_rd;
            m_valid = 1'b1;
        end else if (op_ready) m_valid = 1'b0;
        if (wb_en) begin
            m_busy[wb_addr] = 1'b0;
            if (wb_addr != 0) m_reg[wb_addr] = wb_data;
        end
        if (last_acc && req_rd != 0) m_busy[req_rd] = 1'b1;
        @(posedge clk);
        #1;
        chk("op_valid", {31'b0, op_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("r1", r1, m_r1);
            chk("r2", r2, m_r2);
            chk("op_rd", {27'b0, op_rd}, {27'b0, m_rd});
        end
        @(negedge clk);
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1'b1;
        wb_addr = a;
        wb_data = d;
        cycle();
        wb_en = 1'b0;
    endtask

    initial begin
        logic [31:0] held;
        int waited;
        model_clear();
        @(negedge clk);
        apply_reset();

        // Reset while an operand is held
        req_valid = 1'b1; req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd9; op_ready = 1'b0;
        cycle();
        chk("pre_rst_full", {31'b0, op_valid}, 32'd1);
        req_valid = 1'b0;
        apply_reset();
        req_valid = 1'b1; req_rs = 5'd9; req_rt = 5'd9; req_rd = 5'd9; op_ready = 1'b1;
        #1;
        chk("rst_busy_clear_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0;
        cycle();

        // Basic fetch
        wb(5'd3, 32'h5452_4000);
        wb(5'd4, 32'h4592_0000);
        req_valid = 1'b1; req_rs = 5'd3; req_rt = 5'd4; req_rd = 5'd5;
        cycle();
        chk("t2_r1", r1, 32'h5452_4000);
        chk("t2_r2", r2, 32'h4592_0000);
        chk("t2_op_rd", {27'b0, op_rd}, 32'd5);

        // Backpressure with a queued independent request
        op_ready = 1'b0; req_rd = 5'd6;
        held = r1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t3_hold_r1", r1, held);
        end
        op_ready = 1'b1;
        cycle();
        chk("t3_next_rd", {27'b0, op_rd}, 32'd6);

        // RAW hazard on register 5
        req_rs = 5'd5; req_rt = 5'd0; req_rd = 5'd7;
        #1;
        chk("t4_stall", {31'b0, req_ready}, 32'd0);
        cycle();
        cycle();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55D2_4000;
        cycle();
        wb_en = 1'b0;
        chk("t4_acc_in_wb", {31'b0, last_acc}, {31'b0, bypass_on()});
        waited = 0;
        while (!last_acc && waited < 3) begin
            cycle();
            waited++;
        end
        chk("t4_accepted", {31'b0, last_acc}, 32'd1);
        chk("t4_r1", r1, 32'h55D2_4000);
        req_valid = 1'b0;

        // Register 0 ignores writes and never stalls
        wb(5'd0, 32'hFFFF_FFFF);
        req_valid = 1'b1; req_rs = 5'd0; req_rt = 5'd0; req_rd = 5'd0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t5_acc", {31'b0, last_acc}, 32'd1);
            chk("t5_r1", r1, 32'd0);
            chk("t5_r2", r2, 32'd0);
        end
        req_valid = 1'b0;

        // Full-rate independent stream
        wb(5'd6, 32'h0);
        wb(5'd7, 32'h0);
        for (int i = 8; i < 16; i++) wb(5'(i), $urandom);
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_rs = 5'(8 + i); req_rt = 5'(15 - i); req_rd = 5'(16 + i);
            cycle();
            chk("t6_valid", {31'b0, op_valid}, 32'd1);
            chk("t6_op_rd", {27'b0, op_rd}, 32'(16 + i));
        end
        req_valid = 1'b0;
        cycle();
        chk("t6_drain", {31'b0, op_valid}, 32'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            req_valid = $urandom_range(0, 3) != 0;
            req_rs = 5'($urandom_range(0, 12));
            req_rt = 5'($urandom_range(0, 12));
            req_rd = 5'($urandom_range(0, 12));
            op_ready = $urandom_range(0, 3) != 0;
            wb_en = $urandom_range(0, 1) == 1;
            wb_addr = 5'($urandom_range(0, 12));
            wb_data = $urandom;
            cycle();
        end
        wb_en = 1'b0;
        req_valid = 1'b0;
        op_ready = 1'b0;
        apply_reset();
        op_ready = 1'b1;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
